// File: rtl/spi_responder_pkg.sv
// rtl/spi_responder_pkg.sv - shared types and flag positions for the SPI responder
//
// Purpose: FSM state encoding and helpers that locate the status flags at the
//          top of the outgoing frame.
// Contents: state_e, DEF_FRAME_BITS, new_bit_pos(), ovr_bit_pos()
package spi_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int DEF_FRAME_BITS = 16;

  // The flags sit in the two MSBs of the frame, whatever its length.
  function automatic int new_bit_pos(input int frame_bits);
    return frame_bits - 1;
  endfunction

  function automatic int ovr_bit_pos(input int frame_bits);
    return frame_bits - 2;
  endfunction

endpackage

// File: rtl/spi_responder_sync.sv
// rtl/spi_responder_sync.sv - 2-flop synchronizer with rise/fall detect
//
// Purpose: bring one asynchronous pin into the clk domain and flag its edges.
// Ports:
//   clk, nreset        : system clock, async active-low reset
//   d_i                : asynchronous pin
//   q_o                : synchronized level
//   rise_o / fall_o    : one-cycle edge strobes, 2 clk after the pin moves
//                        (registered by the consumer on the 3rd edge)
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic nreset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] synchronizer, [2] previous synchronized value for edge detect.
  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sh_q <= {3{RESET_VAL}};
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  assign q_o    = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder returning the latest ADC sample
//
// Purpose: hold the newest ADC sample with new/overrun flags, shift it out on
//          MISO MSB first, and collect the controller's MOSI word.
// Ports:
//   clk, nreset              : system clock, async active-low reset
//   sample, sample_valid     : ADC result and its one-cycle strobe
//   sclk, ncs, mosi          : asynchronous SPI inputs (oversampled)
//   miso, miso_oe            : SPI data out and pad output enable
//   rx_data, rx_valid        : last complete MOSI word and its update pulse
//   busy                     : frame in progress
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int SAMPLE_W   = 10,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [SAMPLE_W-1:0]   sample,
  input  logic                  sample_valid,
  input  logic                  sclk,
  input  logic                  ncs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int CNT_W   = $clog2(FRAME_BITS + 1);
  localparam int NEW_BIT = new_bit_pos(FRAME_BITS);
  localparam int OVR_BIT = ovr_bit_pos(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, mosi_s;
  logic unused_sclk_lvl, unused_ncs_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .nreset(nreset), .d_i(sclk),
    .q_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // Chip select idles high; resetting its synchronizer high avoids a
  // phantom frame start when reset releases.
  spi_sync #(.RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .nreset(nreset), .d_i(ncs),
    .q_o(unused_ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .nreset(nreset), .d_i(mosi),
    .q_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  state_e                state_q;
  logic [FRAME_BITS-1:0] tx_q, rx_sh_q, rx_data_q, tx_word, rx_next;
  logic [CNT_W-1:0]      cnt_q;
  logic                  miso_q, miso_oe_q, busy_q, rx_valid_q;
  logic [SAMPLE_W-1:0]   hold_q, hold_d;
  logic                  new_q, new_d, ovr_q, ovr_d;
  logic                  done_hit;

  // Final SCLK rise of the frame; chip-select release takes priority.
  assign done_hit = (state_q == ST_ACTIVE) && !ncs_rise && sclk_rise &&
                    (cnt_q == LAST_CNT);
  assign rx_next  = {rx_sh_q[FRAME_BITS-2:0], mosi_s};

  always_comb begin
    tx_word                 = '0;
    tx_word[SAMPLE_W-1:0]   = hold_q;
    tx_word[NEW_BIT]        = new_q;
    tx_word[OVR_BIT]        = ovr_q;
  end

  // A new sample beats a simultaneous end-of-frame clear: the fresh sample
  // is unread, while the overrun it would have caused was already reported.
  always_comb begin
    hold_d = hold_q;
    new_d  = new_q;
    ovr_d  = ovr_q;
    if (sample_valid) begin
      hold_d = sample;
      new_d  = 1'b1;
      ovr_d  = done_hit ? 1'b0 : (ovr_q | new_q);
    end else if (done_hit) begin
      new_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hold_q <= '0;
      new_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      new_q  <= new_d;
      ovr_q  <= ovr_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ncs_fall) begin
            state_q   <= ST_ACTIVE;
            tx_q      <= tx_word;
            cnt_q     <= '0;
            miso_q    <= tx_word[FRAME_BITS-1];
            miso_oe_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (ncs_rise) begin
            state_q   <= ST_IDLE;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (sclk_rise) begin
            rx_sh_q <= rx_next;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (done_hit) begin
              state_q    <= ST_DONE;
              rx_valid_q <= 1'b1;
              rx_data_q  <= rx_next;
              miso_q     <= 1'b0;
            end
          end else if (sclk_fall) begin
            tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
            miso_q <= tx_q[FRAME_BITS-2];
          end
        end
        ST_DONE: begin
          if (ncs_rise) begin
            state_q   <= ST_IDLE;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign busy     = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI peripheral (responder) that lets an external microcontroller read the latest ADC sample over a second SPI link, with the FPGA acting as the target device. The design's ADC interface captures 10-bit voltages. This block holds the most recent sample and serialises it with status flags on MISO. It also collects the 16-bit word the controller shifts in on MOSI. All SPI inputs are oversampled in the single system clock domain.

## Interface
- `SAMPLE_W`, default 10: sample width; must be ≤ `FRAME_BITS`-2.
- `FRAME_BITS`, default 16: SCLK cycles per complete frame.
- `clk` in 1: system clock (40 MHz board clock).
- `nreset` in 1: asynchronous, active-low reset.
- `sample` in `SAMPLE_W`: new ADC result.
- `sample_valid` in 1: one-cycle strobe; `sample` is valid in this cycle.
- `sclk` in 1: SPI clock from the controller, asynchronous to `clk`.
- `ncs` in 1: SPI chip select, active low, asynchronous.
- `mosi` in 1: controller-to-responder data, asynchronous.
- `miso` out 1: responder-to-controller data.
- `miso_oe` out 1: output enable for the MISO pad buffer.
- `rx_data` out `FRAME_BITS`: last complete MOSI word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high while a frame is in progress.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), MSB first. Controller samples MISO on SCLK rise; responder samples MOSI on SCLK rise.
- `sclk`, `ncs` and `mosi` each pass through a 2-flop synchronizer followed by an edge-detect flop.
- Holding register: `sample_valid` loads `sample` into `hold` and sets `new_flag`. If `new_flag` is already set at that point, `overrun_flag` is also set.
- TX word: {`new_flag`, `overrun_flag`, zeros, `hold`}, `FRAME_BITS` wide, MSB first.
- States:
  - IDLE to ACTIVE on synced `ncs` fall. The TX word is snapshotted into the shift register, the bit count is cleared, and MSB is driven on `miso`.
  - ACTIVE: on each SCLK rise, shift `mosi` into the RX shifter and increment the bit count. On each SCLK fall, drive the next TX bit.
  - DONE: entered when the bit count reaches `FRAME_BITS`. Pulse `rx_valid`, load `rx_data`, clear `new_flag` and `overrun_flag`. Any further SCLK edges are ignored and `miso` is driven 0.
  - Return to IDLE on synced `ncs` rise, from either ACTIVE or DONE.
- Aborted frame (`ncs` rises before `FRAME_BITS` rises): no `rx_valid`, `rx_data` unchanged, flags not cleared.
- Flag clear coinciding with `sample_valid`: the set wins, giving `new_flag`=1 and `overrun_flag`=0. `hold` always takes the new sample.
- `sample_valid` during a frame updates `hold` but not the in-flight shift register.
- `miso_oe` = 1 whenever not in IDLE. `busy` = 1 in ACTIVE or DONE.
- Reset, asynchronous and taking effect mid-frame too: state IDLE; `miso`=0, `miso_oe`=0, `busy`=0, `rx_valid`=0, `rx_data`=0, `hold`=0, both flags 0.

## Timing
- SCLK high and low times must each be ≥ 4 `clk` periods, so SCLK ≤ 5 MHz at 40 MHz.
- `ncs` fall to first SCLK rise must be ≥ 4 `clk` periods.
- Input latency: 3 `clk` from a pin edge to the detected edge.
- MSB appears on `miso` 3 `clk` after the `ncs` fall. Each later bit appears 3–4 `clk` after the SCLK fall.
- `rx_valid` asserts 3–4 `clk` after the 16th SCLK rise and lasts exactly 1 `clk`.
- `miso_oe` deasserts 3 `clk` after the `ncs` rise.

## Structure
- Package `spi_responder_pkg`: state enum (IDLE, ACTIVE, DONE) and flag bit positions (`NEW_BIT` = `FRAME_BITS`-1, `OVR_BIT` = `FRAME_BITS`-2).
- Sub-module `spi_sync`: 2-flop synchronizer plus rise/fall detect. Instantiated for `sclk` and `ncs`; also for `mosi`, with its edge outputs unused.

## Test plan
- Reset, then a `sample_valid` strobe with `sample`=10'h2A5, then a full 16-bit frame with MOSI=16'hC3A5. Required: MISO reads 16'h82A5, one `rx_valid` pulse, `rx_data`=16'hC3A5, then a second frame reads 16'h02A5.
- Two strobes (10'h001, then 10'h3FF) with no read in between. Required: frame reads 16'hC3FF.
- Abort after 7 SCLK cycles, then a full frame. Required: no `rx_valid` on the abort; the full frame still reports `new_flag`=1.
- `sample_valid` (10'h155) in the same cycle as the DONE flag clear. Required: next frame reads 16'h8155.
- 20 SCLK cycles in one frame. Required: exactly one `rx_valid`; bits 17–20 on MISO are 0.
- `nreset` low mid-frame at bit 9. Required: `miso`, `miso_oe`, `busy` and `rx_data` all 0; a fresh frame after release behaves normally.
